jstk_spi_responder: RTL
=======================

# jstk_spi_responder

SPI slave that emulates a PmodJSTK on the far end of the joystick link, driven by the existing PmodJSTK master controller. It answers each 5-byte frame with a snapshot of supplied X/Y/button values and decodes the master's first byte as an LED command. It is used as a board-to-board joystick bridge and as the bench model behind the game controller's joystick inputs.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on ss_n, sclk and mosi (minimum 2)
- FRAME_BYTES, 5, bytes per transaction

Ports:
- clk  input  1  system clock; must run at least 8x the SCLK frequency
- reset  input  1  synchronous, active-high
- ss_n  input  1  slave select from master, active low (asynchronous to clk)
- sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
- mosi  input  1  master-out data, MSB first
- miso  output  1  slave-out data, MSB first
- x_pos  input  10  X position to report
- y_pos  input  10  Y position to report
- buttons  input  3  {btn2, btn1, jstk_btn} to report
- led  output  2  last accepted LED command {led2, led1}
- cmd_valid  output  1  one-cycle pulse when a valid LED command is accepted
- frame_done  output  1  one-cycle pulse when a complete 40-bit frame ends
- busy  output  1  high while a frame is in progress

## Operation
- ss_n, sclk, mosi pass through SYNC_STAGES flip-flops; edges of synchronized sclk/ss_n detected by comparing with a delayed copy.
- States: IDLE, ARMED, SHIFT, DONE.
  - IDLE: wait for synced ss_n high (guarantees a clean frame start after reset). -> ARMED.
  - ARMED: on ss_n falling edge, snapshot tx word {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons} into 40-bit shift register; drive miso = bit 39; bit_cnt = 0; -> SHIFT.
  - SHIFT: sclk rising: sample mosi into rx byte, bit_cnt++. sclk falling: shift tx left, miso = next bit. After bit 7 of byte 0: if rx[7:2] == 6'b100000, led <= rx[1:0] and pulse cmd_valid; otherwise led unchanged, no pulse. After bit 39 -> DONE.
  - DONE: miso held 0; further sclk edges ignored; on ss_n rising pulse frame_done, -> ARMED.
  - ss_n rising while in SHIFT (aborted frame): no frame_done, busy drops, -> ARMED; any LED command already accepted from a completed byte 0 stays.
- busy = 1 in SHIFT and DONE.
- miso = 0 whenever ss_n synced high (no tri-state inside this block).
- x_pos/y_pos/buttons changes during a frame have no effect on that frame.
- bit_cnt is 6 bits, saturates at 40; never wraps.

## Timing
- Reset values: miso 0, led 2'b00, cmd_valid 0, frame_done 0, busy 0; state IDLE; shift registers 0.
- Input-to-action latency: SYNC_STAGES+1 clk cycles from a pin edge.
- First MISO bit valid SYNC_STAGES+1 clk after ss_n falls; master must wait at least SYNC_STAGES+2 clk before first sclk rise (PmodJSTK master's 25 us SS-to-SCLK gap satisfies this).
- miso updates SYNC_STAGES+1 clk after each sclk fall, well inside the half period at clk >= 8x SCLK.
- cmd_valid: asserted for exactly 1 clk, SYNC_STAGES+1 clk after the 8th sclk rise.
- frame_done: asserted for exactly 1 clk, SYNC_STAGES+1 clk after ss_n rises following bit 40.
- Reset asserted mid-frame: all outputs to reset values the next clk; block returns to IDLE and ignores the rest of that frame until ss_n is seen high.

## Test plan
- Full frame: x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101, MOSI byte 0 = 8'h83 -> MISO bytes 8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05; led=2'b11; one cmd_valid; one frame_done; busy high from ss_n fall to ss_n rise.
- Invalid command: MOSI byte 0 = 8'h40 after prior led=2'b11 -> led stays 2'b11, no cmd_valid, frame_done still pulses.
- Snapshot: change x_pos 10'h000 -> 10'h3FF after ss_n falls -> frame reports 8'h00, 8'h00 for X; next frame reports 8'hFF, 8'h03.
- Aborted frame: raise ss_n after 12 bits with byte 0 = 8'h81 -> led = 2'b01, cmd_valid once, no frame_done; next full frame completes normally.
- Overrun: 48 sclk pulses in one frame -> bits 41-48 on MISO all 0, single frame_done, led decoded from byte 0 only.
- Reset mid-frame at bit 20 with ss_n held low -> outputs at reset values; remaining sclks ignored; no frame_done; frame after ss_n high-then-low completes correctly.

Source files
------------

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a PmodJSTK: answers each frame with a snapshot of
// X/Y/button values and decodes the master's first byte as an LED command.
//   state | meaning
//   IDLE  | wait for ss_n seen high before accepting a frame
//   ARMED | wait for ss_n fall, then snapshot tx word
//   SHIFT | exchange bits on sclk edges
//   DONE  | frame complete; ignore sclk until ss_n rises
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       cmd_valid,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BYTES * 8 - 1);
    localparam logic [5:0] MAX_CNT  = 6'(FRAME_BYTES * 8);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic        ss_d, sclk_d;
    logic        ss_s, sclk_s, mosi_s;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [39:0] tx_sr;
    logic [39:0] tx_word;
    logic [7:0]  rx_byte, rx_next;
    logic [5:0]  bit_cnt;
    logic        miso_r;
    logic        load, sample, shift, cmd_hit, done_pulse;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    assign rx_next = {rx_byte[6:0], mosi_s};
    assign tx_word = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons};

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_d      <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        sample     = 1'b0;
        shift      = 1'b0;
        cmd_hit    = 1'b0;
        done_pulse = 1'b0;
        case (state)
            IDLE: if (ss_s) state_nxt = ARMED;
            ARMED: begin
                if (ss_fall) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // ss_n rising mid-frame aborts without frame_done
                if (ss_rise) begin
                    state_nxt = ARMED;
                end else if (sclk_rise) begin
                    sample = 1'b1;
                    if (bit_cnt == 6'd7 && rx_next[7:2] == 6'b100000) cmd_hit = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = DONE;
                end else if (sclk_fall) begin
                    shift = 1'b1;
                end
            end
            DONE: begin
                if (ss_rise) begin
                    done_pulse = 1'b1;
                    state_nxt  = ARMED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr      <= '0;
            rx_byte    <= '0;
            bit_cnt    <= '0;
            miso_r     <= 1'b0;
            led        <= 2'b00;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cmd_valid  <= cmd_hit;
            frame_done <= done_pulse;
            if (load) begin
                tx_sr   <= tx_word;
                miso_r  <= tx_word[39];
                bit_cnt <= '0;
                rx_byte <= '0;
            end
            if (sample) begin
                rx_byte <= rx_next;
                if (bit_cnt != MAX_CNT) bit_cnt <= bit_cnt + 6'd1;
            end
            if (shift) begin
                tx_sr  <= {tx_sr[38:0], 1'b0};
                miso_r <= tx_sr[38];
            end
            if (cmd_hit) led <= rx_next[1:0];
            if (state_nxt != SHIFT) miso_r <= 1'b0;
        end
    end

    assign miso = miso_r & ~ss_s;
    assign busy = (state == SHIFT) || (state == DONE);

endmodule
